// File: rtl/deferred_report_queue_if.sv
// Port bundle for deferred_report_queue: tentative report input, flush/commit
// controls, matured-report valid/ready output and status counters.
interface deferred_report_queue_if #(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned OP_W       = 32,
    parameter int unsigned PEND_DEPTH = 8
);
    logic                          rep_valid;
    logic [ID_W-1:0]               rep_id;
    logic [OP_W-1:0]               rep_opcode;
    logic                          flush;
    logic                          commit;
    logic                          out_valid;
    logic                          out_ready;
    logic [ID_W-1:0]               out_id;
    logic                          out_type;
    logic                          out_illegal;
    logic [$clog2(PEND_DEPTH):0]   pend_count;
    logic [7:0]                    drop_count;
    logic                          busy;

    modport master (
        output rep_valid, rep_id, rep_opcode, flush, commit, out_ready,
        input  out_valid, out_id, out_type, out_illegal, pend_count, drop_count, busy
    );

    modport slave (
        input  rep_valid, rep_id, rep_opcode, flush, commit, out_ready,
        output out_valid, out_id, out_type, out_illegal, pend_count, drop_count, busy
    );
endinterface

// File: rtl/deferred_report_queue.sv
// Deferred-assertion failure report queue: tentative reports are flushed or matured,
// classified, and delivered through an output FIFO. Optional: DEFERRED_REPORT_DEDUP_EN.
module deferred_report_queue #(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned OP_W       = 32,
    parameter int unsigned PEND_DEPTH = 8,
    parameter int unsigned OUT_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    deferred_report_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(PEND_DEPTH);
    localparam int unsigned OW = $clog2(OUT_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [OP_W-1:0] opcode;
    } pend_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            typ;
        logic            illegal;
    } out_t;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t        state;
    pend_t         pend_mem [PEND_DEPTH];
    logic [PW-1:0] pend_rd, pend_wr;
    logic [PW:0]   pend_cnt, snap;
    out_t          out_mem [OUT_DEPTH];
    logic [OW-1:0] out_rd, out_wr;
    logic [OW:0]   out_cnt;
    logic [7:0]    drops;

    logic  pend_full, out_full, pend_pop, pend_push, drop, dup, out_pop;
    pend_t head;
    out_t  head_cls, out_head;

    assign pend_full = (pend_cnt == (PW+1)'(PEND_DEPTH));
    assign out_full  = (out_cnt == (OW+1)'(OUT_DEPTH));
    assign pend_pop  = (state == DRAIN) && !bus.flush && !out_full;
    assign pend_push = bus.rep_valid && (bus.flush || (!dup && (!pend_full || pend_pop)));
    assign drop      = bus.rep_valid && !bus.flush && !dup && pend_full && !pend_pop;
    assign out_pop   = bus.out_valid && bus.out_ready;

    // Classify the pending head as it moves into the output FIFO
    always_comb begin
        head             = pend_mem[pend_rd];
        head_cls.id      = head.id;
        head_cls.typ     = (head.opcode >= OP_W'(32));
        head_cls.illegal = (head.opcode >= OP_W'(64));
    end

`ifdef DEFERRED_REPORT_DEDUP_EN
    // Match against live pending entries; the head leaving this cycle does not count
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < int'(PEND_DEPTH); i++) begin
            if (({1'b0, PW'(PW'(i) - pend_rd)} < pend_cnt) &&
                !(pend_pop && (PW'(i) == pend_rd)) &&
                (pend_mem[i].id == bus.rep_id))
                dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (pend_push) pend_mem[bus.flush ? '0 : pend_wr] <= '{id: bus.rep_id, opcode: bus.rep_opcode};
        if (pend_pop)  out_mem[out_wr] <= head_cls;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_rd  <= '0;
            pend_wr  <= '0;
            pend_cnt <= '0;
            snap     <= '0;
            out_rd   <= '0;
            out_wr   <= '0;
            out_cnt  <= '0;
            drops    <= '0;
        end else begin
            if (bus.flush) begin
                pend_rd  <= '0;
                pend_wr  <= pend_push ? PW'(1) : '0;
                pend_cnt <= pend_push ? (PW+1)'(1) : '0;
            end else begin
                if (pend_pop)  pend_rd <= pend_rd + PW'(1);
                if (pend_push) pend_wr <= pend_wr + PW'(1);
                pend_cnt <= pend_cnt + (PW+1)'(pend_push) - (PW+1)'(pend_pop);
            end

            if (drop && (drops != 8'hFF)) drops <= drops + 8'd1;

            if (pend_pop) out_wr <= out_wr + OW'(1);
            if (out_pop)  out_rd <= out_rd + OW'(1);
            out_cnt <= out_cnt + (OW+1)'(pend_pop) - (OW+1)'(out_pop);

            // Commit snapshots the current occupancy; later arrivals wait for the next commit
            case (state)
                IDLE: begin
                    if (bus.commit && !bus.flush && (pend_cnt != '0)) begin
                        snap  <= pend_cnt;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        snap  <= '0;
                        state <= IDLE;
                    end else if (pend_pop) begin
                        snap <= snap - (PW+1)'(1);
                        if (snap == (PW+1)'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_head        = out_mem[out_rd];
    assign bus.out_valid   = (out_cnt != '0);
    assign bus.out_id      = bus.out_valid ? out_head.id : '0;
    assign bus.out_type    = bus.out_valid & out_head.typ;
    assign bus.out_illegal = bus.out_valid & out_head.illegal;
    assign bus.pend_count  = pend_cnt;
    assign bus.drop_count  = drops;
    assign bus.busy        = (state == DRAIN);
endmodule
